// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and types for the frame/data RAM port-A clients.
// The selection word lives at a fixed byte address and is read as 4 little-endian bytes.
package mem_map_pkg;

    localparam int ADDR_W = 19;
    localparam logic [ADDR_W-1:0] SELECTION_WORD_ADDR = 19'h30E50;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_word_reader_if.sv
// Request/response handshake between the CPU side and the RAM word reader.
// The master starts a read and receives busy/done and the assembled word.
interface ram_word_reader_if #(
    parameter int ADDR_W = 19
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [31:0]       data_out;

    modport master (
        output start,
        output base_addr,
        input  busy,
        input  done,
        input  data_out
    );

    modport slave (
        input  start,
        input  base_addr,
        output busy,
        output done,
        output data_out
    );

endinterface

// File: rtl/read_valid_pipe.sv
// Shift register tracking outstanding RAM reads; its output marks the cycle
// whose closing edge samples the byte issued RD_LAT edges earlier.
module read_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vld_in,
    output logic vld_out
);

    logic [RD_LAT-1:0] vld_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | RD_LAT'(vld_in);
        end
    end

    assign vld_out = vld_p[RD_LAT-1];

endmodule

// File: rtl/ram_word_reader.sv
// Fetches one 32-bit little-endian word through the byte-wide RAM port A by
// issuing four consecutive byte reads and assembling them into data_out.
module ram_word_reader #(
    parameter int ADDR_W = mem_map_pkg::ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_word_reader_if.slave  rd,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_writedata,
    output logic              ram_write_enable,
    input  logic [7:0]        q_in
);

    import mem_map_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [ADDR_W-1:0] base_reg;
    logic [1:0]        ii;
    logic [1:0]        ii_inc;
    logic [1:0]        ci;
    logic [23:0]       shadow;
    logic              accept;
    logic              issue;
    logic              cap;
    logic              last_cap;

    // busy is low in IDLE and DONE, so a start in the DONE cycle chains the next word
    assign accept   = rd.start && !rd.busy;
    assign issue    = accept || ((state == READ) && (ii != LAST_IDX));
    assign last_cap = cap && (ci == LAST_IDX);
    assign ii_inc   = ii + 2'd1;

    assign ram_writedata    = 8'h00;
    assign ram_write_enable = 1'b0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (last_cap) state_nxt = DONE;
            DONE:    state_nxt = accept ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rd.busy <= 1'b0;
            rd.done <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd.busy <= (state_nxt == READ);
            rd.done <= (state_nxt == DONE);
        end
    end

    // Issue side: address register walks base..base+3 and then holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg    <= '0;
            ii          <= 2'd0;
            ram_address <= '0;
        end else if (accept) begin
            base_reg    <= rd.base_addr;
            ii          <= 2'd0;
            ram_address <= rd.base_addr;
        end else if (issue) begin
            ii          <= ii_inc;
            ram_address <= base_reg + ADDR_W'(ii_inc);
        end
    end

    read_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_vld_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .vld_in  (issue),
        .vld_out (cap)
    );

    // Capture side: bytes 0..2 land in the shadow, byte 3 completes the word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ci          <= 2'd0;
            shadow      <= '0;
            rd.data_out <= '0;
        end else if (accept) begin
            ci <= 2'd0;
        end else if (cap) begin
            ci <= ci + 2'd1;
            unique case (ci)
                2'd0:    shadow[7:0]   <= q_in;
                2'd1:    shadow[15:8]  <= q_in;
                2'd2:    shadow[23:16] <= q_in;
                default: rd.data_out   <= {q_in, shadow};
            endcase
        end
    end

endmodule
